// File: rtl/mem_fifo_ctrl_if.sv
// Valid/ready stream bundle for mem_fifo_ctrl: producer side (in_*) and consumer side (out_*).
// The controller takes the slave modport; the producer/consumer environment takes the master.
interface mem_fifo_ctrl_if #(
   parameter int unsigned DATA_W = 16
) ();

   logic              in_valid;
   logic              in_ready;
   logic [DATA_W-1:0] in_data;
   logic              out_valid;
   logic              out_ready;
   logic [DATA_W-1:0] out_data;

   modport master (
      output in_valid,
      output in_data,
      output out_ready,
      input  in_ready,
      input  out_valid,
      input  out_data
   );

   modport slave (
      input  in_valid,
      input  in_data,
      input  out_ready,
      output in_ready,
      output out_valid,
      output out_data
   );

endinterface

// File: rtl/mem_fifo_ctrl.sv
// FIFO controller in front of a 16x16 synchronous memory; one fairly arbitrated access per cycle.
// Optional MEM_FIFO_BYPASS_EN: an empty FIFO loads in_data straight into the head register.
module mem_fifo_ctrl #(
   parameter int unsigned DATA_W = 16,
   parameter int unsigned ADDR_W = 4
) (
   input  logic              clk,
   input  logic              rst_n,
   mem_fifo_ctrl_if.slave    bus,
   output logic [ADDR_W:0]   mem_count,
   output logic              full,
   output logic              empty,
   output logic [ADDR_W-1:0] mem_addr,
   output logic              mem_we,
   output logic              mem_oe,
   output logic [DATA_W-1:0] mem_wdata,
   input  logic [DATA_W-1:0] mem_rdata
);

   localparam logic [ADDR_W:0] FullCount = {1'b1, {ADDR_W{1'b0}}};
   localparam logic [ADDR_W:0] OneCount  = {{ADDR_W{1'b0}}, 1'b1};

   logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
   logic [ADDR_W-1:0] rd_ptr_q, rd_ptr_d;
   logic [ADDR_W:0]   count_q, count_d;
   logic              out_valid_q, out_valid_d;
   logic [DATA_W-1:0] out_data_q, out_data_d;
   logic              last_grant_q, last_grant_d;

   logic full_int, empty_int;
   logic head_free;
   logic wr_req, rd_req;
   logic grant_wr, grant_rd;
   logic bypass;

   assign full_int  = (count_q == FullCount);
   assign empty_int = (count_q == '0);
   assign head_free = !out_valid_q || bus.out_ready;

   // Requests are gated by rst_n so nothing reaches the memory while reset is held.
   assign wr_req = rst_n && bus.in_valid && !full_int;
   assign rd_req = rst_n && !empty_int && head_free;

`ifdef MEM_FIFO_BYPASS_EN
   assign bypass = rst_n && empty_int && head_free && bus.in_valid;
`else
   assign bypass = 1'b0;
`endif

   // last_grant_q = 1 means write won last time, so a contested cycle goes to read.
   always_comb begin
      grant_wr = 1'b0;
      grant_rd = 1'b0;
      if (wr_req && rd_req) begin
         grant_wr = !last_grant_q;
         grant_rd = last_grant_q;
      end else begin
         grant_wr = wr_req;
         grant_rd = rd_req;
      end
      if (bypass) begin
         grant_wr = 1'b0;
      end
   end

   always_comb begin
      mem_we   = grant_wr;
      mem_oe   = grant_rd;
      mem_addr = grant_wr ? wr_ptr_q : rd_ptr_q;
   end

   assign mem_wdata = bus.in_data;

   always_comb begin
      wr_ptr_d     = wr_ptr_q;
      rd_ptr_d     = rd_ptr_q;
      count_d      = count_q;
      out_valid_d  = out_valid_q;
      out_data_d   = out_data_q;
      last_grant_d = last_grant_q;

      if (grant_wr) begin
         wr_ptr_d     = wr_ptr_q + 1'b1;
         count_d      = count_q + OneCount;
         last_grant_d = 1'b1;
      end else if (grant_rd) begin
         rd_ptr_d     = rd_ptr_q + 1'b1;
         count_d      = count_q - OneCount;
         last_grant_d = 1'b0;
      end

      if (grant_rd) begin
         out_valid_d = 1'b1;
         out_data_d  = mem_rdata;
      end else if (bypass) begin
         out_valid_d = 1'b1;
         out_data_d  = bus.in_data;
      end else if (out_valid_q && bus.out_ready) begin
         out_valid_d = 1'b0;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr_q     <= '0;
         rd_ptr_q     <= '0;
         count_q      <= '0;
         out_valid_q  <= 1'b0;
         out_data_q   <= '0;
         last_grant_q <= 1'b1;
      end else begin
         wr_ptr_q     <= wr_ptr_d;
         rd_ptr_q     <= rd_ptr_d;
         count_q      <= count_d;
         out_valid_q  <= out_valid_d;
         out_data_q   <= out_data_d;
         last_grant_q <= last_grant_d;
      end
   end

   assign bus.in_ready  = grant_wr || bypass;
   assign bus.out_valid = out_valid_q;
   assign bus.out_data  = out_data_q;
   assign mem_count     = count_q;
   assign full          = full_int;
   assign empty         = empty_int;

endmodule

// File: tb/tb_mem_fifo_ctrl.sv
// Directed bench for mem_fifo_ctrl with a behavioural 16x16 memory; build with or without
// MEM_FIFO_BYPASS_EN to match the RTL configuration.
module tb_mem_fifo_ctrl;

   logic        clk;
   logic        rst_n;
   logic [4:0]  mem_count;
   logic        full;
   logic        empty;
   logic [3:0]  mem_addr;
   logic        mem_we;
   logic        mem_oe;
   logic [15:0] mem_wdata;
   logic [15:0] mem_rdata;
   logic [15:0] mem [16];

   int vectors;
   int miscompares;

   mem_fifo_ctrl_if #(.DATA_W(16)) bus_if ();

   mem_fifo_ctrl #(.DATA_W(16), .ADDR_W(4)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .bus       (bus_if),
      .mem_count (mem_count),
      .full      (full),
      .empty     (empty),
      .mem_addr  (mem_addr),
      .mem_we    (mem_we),
      .mem_oe    (mem_oe),
      .mem_wdata (mem_wdata),
      .mem_rdata (mem_rdata)
   );

   always @(posedge clk) if (mem_we) mem[mem_addr] <= mem_wdata;
   assign mem_rdata = mem_oe ? mem[mem_addr] : 16'h0000;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: observed no finish, expected finish before 200000");
      $fatal(1, "watchdog");
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic settle();
      #1;
   endtask

   initial begin
      int n;
      int cyc;
      logic acc;
      logic [15:0] rd_exp;
      vectors     = 0;
      miscompares = 0;
      rst_n = 1'b0;
      bus_if.in_valid  = 1'b1;
      bus_if.in_data   = 16'h5555;
      bus_if.out_ready = 1'b0;

      // Reset: handshake and memory pins quiet even with in_valid high.
      #2;
      check("rst_in_ready", bus_if.in_ready, 0);
      check("rst_mem_we", mem_we, 0);
      check("rst_mem_oe", mem_oe, 0);
      check("rst_mem_addr", mem_addr, 0);
      check("rst_out_valid", bus_if.out_valid, 0);
      check("rst_count", mem_count, 0);
      check("rst_empty", empty, 1);
      check("rst_full", full, 0);
      bus_if.in_valid = 1'b0;
      tick();
      tick();
      rst_n = 1'b1;
      #3;

      // Single push of 0xA5A5.
      bus_if.in_valid = 1'b1;
      bus_if.in_data  = 16'hA5A5;
      settle();
`ifdef MEM_FIFO_BYPASS_EN
      check("p1_in_ready", bus_if.in_ready, 1);
      check("p1_we_bypass", mem_we, 0);
      check("p1_oe_bypass", mem_oe, 0);
      tick();
      bus_if.in_valid = 1'b0;
      check("p1_out_valid_1edge", bus_if.out_valid, 1);
      check("p1_out_data", bus_if.out_data, 16'hA5A5);
      check("p1_count", mem_count, 0);
`else
      check("p1_in_ready", bus_if.in_ready, 1);
      check("p1_we", mem_we, 1);
      check("p1_addr", mem_addr, 0);
      tick();
      bus_if.in_valid = 1'b0;
      check("p1_out_valid_e1", bus_if.out_valid, 0);
      check("p1_count_e1", mem_count, 1);
      settle();
      check("p1_rd_oe", mem_oe, 1);
      check("p1_rd_we", mem_we, 0);
      check("p1_rd_addr", mem_addr, 0);
      tick();
      check("p1_out_valid_e2", bus_if.out_valid, 1);
      check("p1_out_data", bus_if.out_data, 16'hA5A5);
      check("p1_count_e2", mem_count, 0);
      check("p1_empty", empty, 1);
`endif
      settle();
      check("p1_no_read_empty", mem_oe, 0);
      bus_if.out_ready = 1'b1;
      tick();
      bus_if.out_ready = 1'b0;
      check("p1_popped", bus_if.out_valid, 0);

      // Fill: 17 words 0x0000..0x0010 with the consumer stalled.
      for (int k = 0; k < 17; k++) begin
         bus_if.in_valid = 1'b1;
         bus_if.in_data  = 16'(k);
         cyc = 0;
         acc = 1'b0;
         while (!acc && cyc < 4) begin
            settle();
            acc = bus_if.in_ready;
            tick();
            cyc++;
         end
         if (!acc) check("fill_timeout", cyc, 0);
      end
      bus_if.in_data = 16'h0011;
      check("fill_full", full, 1);
      check("fill_count", mem_count, 16);
      check("fill_out_valid", bus_if.out_valid, 1);
      check("fill_out_data", bus_if.out_data, 16'h0000);
      settle();
      check("fill_18th_ready", bus_if.in_ready, 0);
      check("fill_18th_we", mem_we, 0);
      tick();
      check("fill_still_full", mem_count, 16);

      // Stream pops from full; order must survive rd_ptr wrap.
      bus_if.in_valid  = 1'b0;
      bus_if.out_ready = 1'b1;
      for (int k = 1; k <= 16; k++) begin
         settle();
         check("pop_oe", mem_oe, 1);
         tick();
         check("pop_data", bus_if.out_data, 32'(k));
         check("pop_valid", bus_if.out_valid, 1);
         if (k == 1) check("pop_full_clear", full, 0);
      end
      check("pop_empty", empty, 1);
      settle();
      check("pop_no_read", mem_oe, 0);
      tick();
      check("pop_drain_valid", bus_if.out_valid, 0);
      check("pop_hold_data", bus_if.out_data, 16'h0010);
      bus_if.out_ready = 1'b0;

      // Fill to 9 starting at 0x0100.
      n = 0;
      cyc = 0;
      while (mem_count != 9 && cyc < 40) begin
         bus_if.in_valid = 1'b1;
         bus_if.in_data  = 16'(16'h0100 + n);
         settle();
         acc = bus_if.in_ready;
         tick();
         if (acc) n++;
         cyc++;
      end
      check("fill9_count", mem_count, 9);
      check("fill9_pushes", n, 10);
      check("fill9_head", bus_if.out_data, 16'h0100);
      bus_if.in_valid  = 1'b0;
      bus_if.out_ready = 1'b1;
      tick();
      check("to8_count", mem_count, 8);
      check("to8_head", bus_if.out_data, 16'h0101);

      // Contested push/pop alternates, starting with write since read won last.
      bus_if.in_valid = 1'b1;
      bus_if.in_data  = 16'h010A;
      rd_exp = 16'h0102;
      for (int i = 0; i < 8; i++) begin
         settle();
         check("alt_we", mem_we, (i % 2 == 0) ? 1 : 0);
         check("alt_oe", mem_oe, (i % 2 == 0) ? 0 : 1);
         check("alt_in_ready", bus_if.in_ready, (i % 2 == 0) ? 1 : 0);
         tick();
         if (i % 2 == 0) begin
            check("alt_count_w", mem_count, 9);
            check("alt_valid_w", bus_if.out_valid, 0);
            bus_if.in_data = bus_if.in_data + 16'h0001;
         end else begin
            check("alt_count_r", mem_count, 8);
            check("alt_valid_r", bus_if.out_valid, 1);
            check("alt_data_r", bus_if.out_data, rd_exp);
            rd_exp = rd_exp + 16'h0001;
         end
      end

      // Drain to 5 then reset mid-stream.
      bus_if.in_valid = 1'b0;
      cyc = 0;
      while (mem_count != 5 && cyc < 10) begin
         tick();
         cyc++;
      end
      check("pre_rst_count", mem_count, 5);
      bus_if.in_valid = 1'b1;
      bus_if.in_data  = 16'h0200;
      #2;
      rst_n = 1'b0;
      #1;
      check("mid_rst_out_valid", bus_if.out_valid, 0);
      check("mid_rst_we", mem_we, 0);
      check("mid_rst_oe", mem_oe, 0);
      check("mid_rst_in_ready", bus_if.in_ready, 0);
      check("mid_rst_addr", mem_addr, 0);
      tick();
      rst_n = 1'b1;
      bus_if.out_ready = 1'b0;
      bus_if.in_data   = 16'hBEEF;
      settle();
      check("post_rst_empty", empty, 1);
      check("post_rst_count", mem_count, 0);
`ifdef MEM_FIFO_BYPASS_EN
      check("post_rst_bypass_ready", bus_if.in_ready, 1);
      check("post_rst_bypass_we", mem_we, 0);
      tick();
      check("post_rst_bypass_head", bus_if.out_data, 16'hBEEF);
      bus_if.in_data = 16'hC0DE;
      settle();
      check("post_rst_we", mem_we, 1);
      check("post_rst_addr", mem_addr, 0);
      tick();
      check("post_rst_count1", mem_count, 1);
`else
      check("post_rst_we", mem_we, 1);
      check("post_rst_addr", mem_addr, 0);
      tick();
      bus_if.in_valid = 1'b0;
      check("post_rst_count1", mem_count, 1);
      tick();
      check("post_rst_head_valid", bus_if.out_valid, 1);
      check("post_rst_head", bus_if.out_data, 16'hBEEF);
`endif

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
